// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared constants for the execute-stage ALU and the ALU control decoder:
// 5-bit op codes, FSM state encoding and shifter operation encoding.
// ----------------------------------------------------------------------------
package alu_pkg;

  localparam int unsigned ALU_OP_W = 5;

  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD  = 5'b00000;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB  = 5'b00010;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLL  = 5'b00100;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLT  = 5'b01000;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLTU = 5'b01100;
  localparam logic [ALU_OP_W-1:0] ALU_OP_XOR  = 5'b10000;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRL  = 5'b10100;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRA  = 5'b10110;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = 5'b11000;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = 5'b11100;
  localparam logic [ALU_OP_W-1:0] ALU_OP_BGE  = 5'b11010;
  localparam logic [ALU_OP_W-1:0] ALU_OP_BGEU = 5'b11110;
  localparam logic [ALU_OP_W-1:0] ALU_OP_LUI  = 5'b11101;
  localparam logic [ALU_OP_W-1:0] ALU_OP_ILL  = 5'b11111;

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } alu_state_e;

  typedef enum logic [1:0] {
    ShSll = 2'd0,
    ShSrl = 2'd1,
    ShSra = 2'd2
  } alu_sh_op_e;

  function automatic logic is_shift_op(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_OP_SLL) || (op == ALU_OP_SRL) || (op == ALU_OP_SRA);
  endfunction

  function automatic alu_sh_op_e sh_op_of(input logic [ALU_OP_W-1:0] op);
    case (op)
      ALU_OP_SRL: return ShSrl;
      ALU_OP_SRA: return ShSra;
      default:    return ShSll;
    endcase
  endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// ----------------------------------------------------------------------------
// alu_shift_unit
// Shifter for sll/srl/sra. Iterative 1-bit-per-cycle by default; a
// combinational barrel shifter when ALU_BARREL_SHIFT_EN is defined.
// Ports:
//   i_clk, i_rst   clock, async active-high reset (unused in barrel build)
//   i_start        load value/amount/op (iterative build)
//   i_op           shift kind
//   iv_value       value to shift
//   iv_amount      shift amount
//   o_done         remaining count is zero (always 1 in barrel build)
//   ov_result      working register (iterative) or shifted value (barrel)
// ----------------------------------------------------------------------------
module alu_shift_unit
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = $clog2(DATA_W)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  alu_sh_op_e         i_op,
  input  logic [DATA_W-1:0]  iv_value,
  input  logic [SHAMT_W-1:0] iv_amount,
  output logic               o_done,
  output logic [DATA_W-1:0]  ov_result
);

`ifdef ALU_BARREL_SHIFT_EN

  logic w_unused;
  assign w_unused = ^{i_clk, i_rst, i_start};

  always_comb begin
    ov_result = iv_value;
    case (i_op)
      ShSll:   ov_result = iv_value << iv_amount;
      ShSrl:   ov_result = iv_value >> iv_amount;
      ShSra:   ov_result = DATA_W'($signed(iv_value) >>> iv_amount);
      default: ov_result = iv_value;
    endcase
  end

  assign o_done = 1'b1;

`else

  logic [DATA_W-1:0]  r_work;
  logic [SHAMT_W-1:0] r_cnt;
  alu_sh_op_e         r_op;
  logic [DATA_W-1:0]  w_step;

  always_comb begin
    w_step = r_work;
    case (r_op)
      ShSll:   w_step = {r_work[DATA_W-2:0], 1'b0};
      ShSrl:   w_step = {1'b0, r_work[DATA_W-1:1]};
      ShSra:   w_step = {r_work[DATA_W-1], r_work[DATA_W-1:1]};
      default: w_step = r_work;
    endcase
  end

  // Counter parks at zero; the top only looks at o_done while in StShift.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_work <= '0;
      r_cnt  <= '0;
      r_op   <= ShSll;
    end else if (i_start) begin
      r_work <= iv_value;
      r_cnt  <= iv_amount;
      r_op   <= i_op;
    end else if (r_cnt != '0) begin
      r_work <= w_step;
      r_cnt  <= r_cnt - SHAMT_W'(1);
    end
  end

  assign o_done    = (r_cnt == '0);
  assign ov_result = r_work;

`endif

endmodule

// File: rtl/alu_exec_unit.sv
// ----------------------------------------------------------------------------
// alu_exec_unit
// Execute-stage ALU. Single-cycle logic/arith/compare/LUI ops; shifts via
// alu_shift_unit (iterative, multi-cycle with valid/ready handshake).
// Build option: ALU_BARREL_SHIFT_EN -> single-cycle barrel shifts, no SHIFT
// state, o_ready tied high.
// Ports:
//   i_clk, i_rst   clock, async active-high reset
//   i_valid        request present
//   o_ready        unit idle; accept on i_valid && o_ready
//   iv_AluOp       5-bit op code
//   iv_A, iv_B     operands
//   o_Valid        one-cycle result pulse
//   ov_Result      result, held until next completion
//   o_Zero         ov_Result == 0
//   o_Illegal      op code unsupported
// ----------------------------------------------------------------------------
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [ALU_OP_W-1:0] iv_AluOp,
  input  logic [DATA_W-1:0]   iv_A,
  input  logic [DATA_W-1:0]   iv_B,
  output logic                o_Valid,
  output logic [DATA_W-1:0]   ov_Result,
  output logic                o_Zero,
  output logic                o_Illegal
);

  localparam int unsigned SHAMT_W = $clog2(DATA_W);

  logic              w_ready;
  logic              w_accept;
  logic              w_is_shift;
  logic              w_load_alu;
  logic              w_load_sh;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_illegal;
  logic              w_sh_done;
  logic [DATA_W-1:0] w_sh_result;

  logic              r_valid;
  logic [DATA_W-1:0] r_result;
  logic              r_zero;
  logic              r_illegal;

  assign w_accept   = i_valid && w_ready;
  assign w_is_shift = is_shift_op(iv_AluOp);

  // Single-cycle datapath; shift codes are legal but produced elsewhere.
  always_comb begin
    w_alu_res = '0;
    w_illegal = 1'b0;
    case (iv_AluOp)
      ALU_OP_ADD:  w_alu_res = iv_A + iv_B;
      ALU_OP_SUB:  w_alu_res = iv_A - iv_B;
      ALU_OP_SLT:  w_alu_res[0] = $signed(iv_A) < $signed(iv_B);
      ALU_OP_SLTU: w_alu_res[0] = iv_A < iv_B;
      ALU_OP_XOR:  w_alu_res = iv_A ^ iv_B;
      ALU_OP_OR:   w_alu_res = iv_A | iv_B;
      ALU_OP_AND:  w_alu_res = iv_A & iv_B;
      ALU_OP_BGE:  w_alu_res[0] = $signed(iv_A) >= $signed(iv_B);
      ALU_OP_BGEU: w_alu_res[0] = iv_A >= iv_B;
      ALU_OP_LUI:  w_alu_res = iv_B;
      ALU_OP_SLL, ALU_OP_SRL, ALU_OP_SRA: w_alu_res = '0;
      default:     w_illegal = 1'b1;
    endcase
  end

  alu_shift_unit #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_shift (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (w_accept && w_is_shift),
    .i_op      (sh_op_of(iv_AluOp)),
    .iv_value  (iv_A),
    .iv_amount (iv_B[SHAMT_W-1:0]),
    .o_done    (w_sh_done),
    .ov_result (w_sh_result)
  );

`ifdef ALU_BARREL_SHIFT_EN

  logic w_unused;
  assign w_unused = w_sh_done;

  assign w_ready    = 1'b1;
  assign w_load_alu = w_accept && !w_is_shift;
  assign w_load_sh  = w_accept && w_is_shift;

`else

  alu_state_e r_state;
  alu_state_e w_state_nxt;
  logic       w_sh_fire;

  always_comb begin
    w_state_nxt = r_state;
    w_sh_fire   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept && w_is_shift) w_state_nxt = StShift;
      end
      StShift: begin
        if (w_sh_done) begin
          w_state_nxt = StIdle;
          w_sh_fire   = 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  assign w_ready    = (r_state == StIdle);
  assign w_load_alu = w_accept && !w_is_shift;
  assign w_load_sh  = w_sh_fire;

`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid   <= 1'b0;
      r_result  <= '0;
      r_zero    <= 1'b1;
      r_illegal <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_load_alu) begin
        r_valid   <= 1'b1;
        r_result  <= w_alu_res;
        r_zero    <= (w_alu_res == '0);
        r_illegal <= w_illegal;
      end else if (w_load_sh) begin
        r_valid   <= 1'b1;
        r_result  <= w_sh_result;
        r_zero    <= (w_sh_result == '0);
        r_illegal <= 1'b0;
      end
    end
  end

  assign o_ready   = w_ready;
  assign o_Valid   = r_valid;
  assign ov_Result = r_result;
  assign o_Zero    = r_zero;
  assign o_Illegal = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// ----------------------------------------------------------------------------
// tb_alu_exec_unit
// Directed table of ops with hand-computed results, plus sequences for
// back-to-back issue, a long sra with a held request, and reset mid-shift.
// ----------------------------------------------------------------------------
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [4:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic        res_valid;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(
    .DATA_W (32)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_valid   (valid),
    .o_ready   (ready),
    .iv_AluOp  (op),
    .iv_A      (a),
    .iv_B      (b),
    .o_Valid   (res_valid),
    .ov_Result (result),
    .o_Zero    (zero),
    .o_Illegal (illegal)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ill;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs[NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [4:0] o, input logic [31:0] bb);
`ifdef ALU_BARREL_SHIFT_EN
    if (o == 5'b11111 && bb == 32'hFFFF_FFFF) return 1;
    return 1;
`else
    if (o == 5'b00100 || o == 5'b10100 || o == 5'b10110) return int'(bb[4:0]) + 2;
    return 1;
`endif
  endfunction

  // Issue one op and wait (bounded) for its completion pulse.
  task automatic run_op(input logic [4:0] o, input logic [31:0] aa, input logic [31:0] bb,
                        output int lat);
    op    = o;
    a     = aa;
    b     = bb;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    lat   = 1;
    while (!res_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int   lat;
    logic saw;
    logic busy_bad;

    vecs[0]  = '{ALU_OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[1]  = '{ALU_OP_SUB,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0};
    vecs[2]  = '{ALU_OP_SUB,  32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b0};
    vecs[3]  = '{ALU_OP_XOR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0};
    vecs[4]  = '{ALU_OP_OR,   32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0};
    vecs[5]  = '{ALU_OP_AND,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0};
    vecs[6]  = '{ALU_OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0};
    vecs[7]  = '{ALU_OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[8]  = '{ALU_OP_BGE,  32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[9]  = '{ALU_OP_BGEU, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0};
    vecs[10] = '{ALU_OP_BGE,  32'h0000_0005, 32'h0000_0005, 32'h0000_0001, 1'b0};
    vecs[11] = '{ALU_OP_BGEU, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1'b0};
    vecs[12] = '{5'b11111,    32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[13] = '{ALU_OP_LUI,  32'h1111_1111, 32'hABCD_E000, 32'hABCD_E000, 1'b0};
    vecs[14] = '{5'b00001,    32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 1'b1};
    vecs[15] = '{ALU_OP_SLL,  32'h0000_0001, 32'h0000_0004, 32'h0000_0010, 1'b0};
    vecs[16] = '{ALU_OP_SRL,  32'h1234_5678, 32'hFFFF_FFE0, 32'h1234_5678, 1'b0};
    vecs[17] = '{ALU_OP_SRL,  32'h8000_0000, 32'h0000_0003, 32'h1000_0000, 1'b0};
    vecs[18] = '{ALU_OP_SRA,  32'h4000_0000, 32'h0000_0002, 32'h1000_0000, 1'b0};
    vecs[19] = '{ALU_OP_SLL,  32'h0000_0001, 32'h0000_0023, 32'h0000_0008, 1'b0};
    vecs[20] = '{ALU_OP_SRA,  32'h8000_00F0, 32'h0000_0004, 32'hF800_000F, 1'b0};

    rst   = 1'b1;
    valid = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready",   32'(ready),     32'd1);
    chk("reset valid",   32'(res_valid), 32'd0);
    chk("reset result",  result,         32'd0);
    chk("reset zero",    32'(zero),      32'd1);
    chk("reset illegal", 32'(illegal),   32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) begin
      chk($sformatf("v%0d ready", i), 32'(ready), 32'd1);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d valid", i),   32'(res_valid), 32'd1);
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(exp_lat(vecs[i].op, vecs[i].b)));
      chk($sformatf("v%0d result", i),  result, vecs[i].res);
      chk($sformatf("v%0d zero", i),    32'(zero), (vecs[i].res == 32'd0) ? 32'd1 : 32'd0);
      chk($sformatf("v%0d illegal", i), 32'(illegal), 32'(vecs[i].ill));
    end

    // slt then sltu back-to-back, request held valid across both edges.
    @(posedge clk); #1;
    op    = ALU_OP_SLT;
    a     = 32'hFFFF_FFFF;
    b     = 32'h0000_0001;
    valid = 1'b1;
    @(posedge clk); #1;
    op = ALU_OP_SLTU;
    chk("b2b slt valid",  32'(res_valid), 32'd1);
    chk("b2b slt result", result,         32'd1);
    chk("b2b slt ready",  32'(ready),     32'd1);
    @(posedge clk); #1;
    valid = 1'b0;
    chk("b2b sltu valid",  32'(res_valid), 32'd1);
    chk("b2b sltu result", result,         32'd0);
    chk("b2b sltu zero",   32'(zero),      32'd1);
    chk("b2b sltu ready",  32'(ready),     32'd1);
    @(posedge clk); #1;
    chk("b2b valid pulse width", 32'(res_valid), 32'd0);

    // sra by 31 with an add held on the inputs while busy.
    op    = ALU_OP_SRA;
    a     = 32'h8000_0000;
    b     = 32'd31;
    valid = 1'b1;
    @(posedge clk); #1;
    op       = ALU_OP_ADD;
    a        = 32'd2;
    b        = 32'd3;
    lat      = 1;
    busy_bad = 1'b0;
    while (!res_valid && lat < 100) begin
      if (ready) busy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk("sra31 ready low while busy", 32'(busy_bad), 32'd0);
    chk("sra31 valid",   32'(res_valid), 32'd1);
    chk("sra31 latency", 32'(lat), 32'(exp_lat(ALU_OP_SRA, 32'd31)));
    chk("sra31 result",  result, 32'hFFFF_FFFF);
    chk("sra31 ready at done", 32'(ready), 32'd1);
    @(posedge clk); #1;
    valid = 1'b0;
    chk("held add valid",  32'(res_valid), 32'd1);
    chk("held add result", result,         32'd5);
    @(posedge clk); #1;

    // sll by 20, reset asserted in the 5th cycle of the operation.
    op    = ALU_OP_SLL;
    a     = 32'h0000_0001;
    b     = 32'd20;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    saw   = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (res_valid) saw = 1'b1;
      @(posedge clk); #1;
    end
    if (res_valid) saw = 1'b1;
    rst = 1'b1;
    #1;
    chk("midrst ready",   32'(ready),     32'd1);
    chk("midrst valid",   32'(res_valid), 32'd0);
    chk("midrst result",  result,         32'd0);
    chk("midrst zero",    32'(zero),      32'd1);
    chk("midrst illegal", 32'(illegal),   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (res_valid) saw = 1'b1;
      @(posedge clk); #1;
    end
    chk("aborted shift completed", 32'(saw), (exp_lat(ALU_OP_SLL, 32'd20) <= 4) ? 32'd1 : 32'd0);
    chk("post-reset ready", 32'(ready), 32'd1);
    run_op(ALU_OP_ADD, 32'd2, 32'd3, lat);
    chk("post-reset add valid",   32'(res_valid), 32'd1);
    chk("post-reset add latency", 32'(lat),       32'd1);
    chk("post-reset add result",  result,         32'd5);
    chk("post-reset add zero",    32'(zero),      32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage ALU, downstream of the ALU control decoder: consumes the 5-bit `ov_AluOp` code together with the two operands and produces the result plus a zero flag for branch resolution. Logic, arithmetic, compare and LUI ops complete in one registered cycle. Shifts run on an iterative 1-bit-per-cycle shifter, so the block uses a valid/ready handshake toward the issue logic. A compile-time option replaces the iterative shifter with a single-cycle barrel shifter.

## Interface
Parameters:
- `DATA_W`, default 32: operand and result width. Shift amount is `B[$clog2(DATA_W)-1:0]`.

Ports:
- `i_clk`: input, 1 bit. Single clock, rising edge.
- `i_rst`: input, 1 bit. Reset is asynchronous and active-high.
- `i_valid`: input, 1 bit. Request present.
- `o_ready`: output, 1 bit. Unit idle; a request is accepted when `i_valid && o_ready` at a rising edge.
- `iv_AluOp`: input, 5 bits. Operation code from ALU control.
- `iv_A`, `iv_B`: input, `DATA_W` bits each. Operands.
- `o_Valid`: output, 1 bit. One-cycle pulse when the result is valid.
- `ov_Result`: output, `DATA_W` bits. Result, held until the next completion.
- `o_Zero`: output, 1 bit. `ov_Result == 0`, registered with the result.
- `o_Illegal`: output, 1 bit. Code is unsupported. Registered with the result.

## Operation
Op codes:
- `00000` add
- `00010` sub
- `00100` sll
- `01000` slt
- `01100` sltu
- `10000` xor
- `10100` srl
- `10110` sra
- `11000` or
- `11100` and
- `11010` bge: result = 1 when A ≥ B signed
- `11110` bgeu: result = 1 when A ≥ B unsigned
- `11101` LUI: result = B
- `11111` and any unlisted code: illegal. Result 0, `o_Illegal` = 1, completes in one cycle.

Arithmetic rules:
- add and sub wrap modulo 2^DATA_W; there is no overflow output.
- Compare results are zero-extended 0 or 1.
- Branch use: beq reads `o_Zero` after sub; bne reads `!o_Zero` after xor.

State machine:
- IDLE: `o_ready` = 1.
  - Non-shift op accepted: compute and register `ov_Result`, `o_Zero` and `o_Illegal`, pulse `o_Valid`, stay in IDLE.
  - Shift op accepted: load A into the working register, load the shift amount into a down-counter, go to SHIFT.
- SHIFT: `o_ready` = 0. Each cycle:
  - Counter == 0: register the result, pulse `o_Valid`, return to IDLE.
  - Otherwise: shift 1 bit (sra replicates the MSB) and decrement the counter.

Boundary conditions:
- `i_valid` while busy: ignored. Upstream holds the request until `o_ready`.
- Shift amount 0: the op still visits SHIFT once; latency 2.
- Bits of B above the shift-amount field are ignored for shifts.
- Reset asserted at any time, including mid-shift: the op is aborted and the unit returns to IDLE with no `o_Valid`.

## Timing
- Reset values: `o_ready` = 1, `o_Valid` = 0, `ov_Result` = 0, `o_Zero` = 1, `o_Illegal` = 0; state IDLE; counter 0.
- Non-shift latency: accepted at edge N, `o_Valid` high in cycle N+1. Throughput is one op per cycle; back-to-back issue is supported.
- Iterative shift latency: shamt+2 cycles from acceptance to `o_Valid`. `o_ready` rises in the same cycle `o_Valid` pulses.
- Outputs are registered only; there is no combinational path from inputs to outputs.

## Configuration
- `ALU_BARREL_SHIFT_EN` defined:
  - Shifts are computed combinationally in the accept cycle, with the same timing as other ops.
  - SHIFT state and counter are not built; `o_ready` is tied to 1.
- Not defined: iterative shifter as described under Operation.

## Structure
- Shared package `alu_pkg`:
  - localparams for every 5-bit op code listed above;
  - state encoding for IDLE and SHIFT;
  - `ALU_OP_W` = 5.
  The ALU control decoder adopts the same constants.
- Sub-module `alu_shift_unit`: iterative or barrel shifter selected by `ALU_BARREL_SHIFT_EN`. Interface: start, op (sll/srl/sra), value, amount, done, result. The top level keeps the handshake and the single-cycle datapath.

## Test plan
- add, A=`0xFFFFFFFF`, B=1 → `ov_Result`=0, `o_Zero`=1, `o_Valid` exactly one cycle after accept.
- slt and sltu with A=`0xFFFFFFFF`, B=1, issued back-to-back → slt result 1 then sltu result 0 on consecutive cycles; `o_ready` held at 1.
- sra, A=`0x80000000`, B=31 → `0xFFFFFFFF` after 33 cycles (iterative); `o_ready` low throughout; a request presented mid-shift is not accepted until `o_ready` returns.
- srl, A=`0x12345678`, B=`0xFFFFFFE0` (shamt 0) → `0x12345678`, latency 2.
- `iv_AluOp`=`11111` → `o_Illegal`=1, `ov_Result`=0; then LUI with B=`0xABCDE000` → `0xABCDE000`, `o_Illegal`=0.
- Reset asserted in the 5th cycle of an sll by 20 → no `o_Valid`, all outputs at reset values. Next add 2+3 → 5 in one cycle.
